// File: rtl/uart_receiver_pkg.sv
// Shared types and frame constants for the UART receive path.
package uart_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int DataBits = 8;
    localparam int StopBits = 1;

    // Smallest n with 2**n >= value; sizes the bit-period counter.
    function automatic int log2_ceil(input int value);
        int result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte-wide valid/ready port carrying received bytes to the consumer.
interface uart_receiver_if;
    logic [7:0] DataOut;
    logic       DataOutValid;
    logic       DataOutReady;

    modport master (output DataOut, output DataOutValid, input DataOutReady);
    modport slave  (input DataOut, input DataOutValid, output DataOutReady);
endinterface

// File: rtl/uart_sync_edge.sv
// Two-flop synchronizer plus falling-edge detector for an asynchronous pin.
// All flops reset to 1 so an idle-high line produces no edge out of reset.
module uart_sync_edge (
    input  logic Clock,
    input  logic Reset,
    input  logic async_in,
    output logic sync_out,
    output logic fall
);
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign sync_out = sync2_q;
    assign fall     = prev_q & ~sync2_q;
endmodule

// File: rtl/uart_receiver.sv
// 8-N-1 UART receiver: mid-bit sampling FSM feeding a one-byte holding register.
//   state | meaning
//   IDLE  | waiting for a falling edge on the synchronized line
//   START | counting to mid start bit; a high sample there is a glitch
//   DATA  | sampling 8 data bits LSB-first, one per bit period
//   STOP  | sampling the stop bit; commit byte or flag framing error
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int ClockFreq = 100_000_000,
    parameter int BaudRate  = 115_200
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             SIn,
    uart_receiver_if.master  rx,
    output logic             FramingError,
    output logic             Overrun
);
    localparam int SymbolEdgeTime    = ClockFreq / BaudRate;
    localparam int SampleTime        = SymbolEdgeTime / 2;
    localparam int ClockCounterWidth = log2_ceil(SymbolEdgeTime);

    localparam logic [ClockCounterWidth-1:0] SymbolLast = ClockCounterWidth'(SymbolEdgeTime - 1);
    localparam logic [ClockCounterWidth-1:0] SampleLast = ClockCounterWidth'(SampleTime - 1);

    if (SymbolEdgeTime < 4) begin : g_bad_rate
        $error("uart_receiver: ClockFreq/BaudRate must be at least 4");
    end
    if (StopBits != 1) begin : g_bad_stop
        $error("uart_receiver: only one stop bit is supported");
    end

    logic sin_sync;
    logic fall;

    uart_sync_edge u_sync_edge (
        .Clock    (Clock),
        .Reset    (Reset),
        .async_in (SIn),
        .sync_out (sin_sync),
        .fall     (fall)
    );

    rx_state_e                    state_q, state_d;
    logic [ClockCounterWidth-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]                   bit_cnt_q, bit_cnt_d;
    logic [DataBits-1:0]          shift_q, shift_d;
    logic                         commit_q, commit_d;
    logic                         frame_err_q, frame_err_d;
    logic [7:0]                   data_q, data_d;
    logic                         valid_q, valid_d;
    logic                         overrun_q, overrun_d;
    logic                         handshake;

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        commit_d    = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (fall) state_d = START;
            end
            START: begin
                if (clk_cnt_q == SampleLast) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = sin_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt_q == SymbolLast) begin
                    clk_cnt_d = '0;
                    shift_d   = {sin_sync, shift_q[DataBits-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(DataBits - 1)) state_d = STOP;
                end
            end
            STOP: begin
                if (clk_cnt_q == SymbolLast) begin
                    clk_cnt_d   = '0;
                    state_d     = IDLE;
                    commit_d    = sin_sync;
                    frame_err_d = ~sin_sync;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A commit coinciding with a handshake refills the register without an overrun.
    always_comb begin
        handshake = valid_q & rx.DataOutReady;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (commit_q) begin
            if (!valid_q || handshake) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (handshake) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            commit_q    <= 1'b0;
            frame_err_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            commit_q    <= commit_d;
            frame_err_q <= frame_err_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx.DataOut      = data_q;
    assign rx.DataOutValid = valid_q;
    assign FramingError    = frame_err_q;
    assign Overrun         = overrun_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit.
module tb_uart_receiver;
    logic Clock = 1'b0;
    logic Reset;
    logic SIn;
    logic FramingError;
    logic Overrun;

    uart_receiver_if rx_if ();

    uart_receiver #(.ClockFreq(16), .BaudRate(1)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .SIn          (SIn),
        .rx           (rx_if),
        .FramingError (FramingError),
        .Overrun      (Overrun)
    );

    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;
    int first_valid = -1;
    int n_valid = 0, n_fe = 0, n_ov = 0;
    int both_cnt = 0, dout_viol = 0;
    logic [7:0] data_at_valid = '0;
    logic [7:0] s_dout = '0;
    logic s_valid = 0, s_fe = 0, s_ov = 0;
    logic prev_valid = 0, prev_hs = 0;
    logic [7:0] prev_data = '0;
    logic [10:0] rst_snap = '1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs just after a rising edge, sample on the falling edge.
    task automatic step(input logic sin, input logic rdy, input logic rst);
        SIn = sin;
        rx_if.DataOutReady = rdy;
        Reset = rst;
        @(negedge Clock);
        s_dout  = rx_if.DataOut;
        s_valid = rx_if.DataOutValid;
        s_fe    = FramingError;
        s_ov    = Overrun;
        if (s_valid && !prev_valid && first_valid < 0) begin
            first_valid   = cyc;
            data_at_valid = s_dout;
        end
        if (prev_valid && s_valid && !prev_hs && s_dout !== prev_data) dout_viol++;
        if (s_fe && s_ov) both_cnt++;
        n_valid += int'(s_valid);
        n_fe    += int'(s_fe);
        n_ov    += int'(s_ov);
        prev_valid = s_valid;
        prev_data  = s_dout;
        prev_hs    = s_valid & rdy;
        cyc++;
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_mon();
        n_valid = 0;
        n_fe = 0;
        n_ov = 0;
        first_valid = -1;
        t0 = cyc;
    endtask

    // 160-cycle frame; optional one-cycle Ready pulse and mid-frame reset (line then idles high).
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic rdy_dflt,
                              input int rdy_at, input int abort_c);
        logic bitv;
        for (int c = 0; c < 160; c++) begin
            if (c < 16) bitv = 1'b0;
            else if (c < 144) bitv = b[(c - 16) / 16];
            else bitv = stop_bit;
            if (abort_c >= 0 && c > abort_c) bitv = 1'b1;
            step(bitv, (c == rdy_at) ? 1'b1 : rdy_dflt, (abort_c >= 0 && c == abort_c));
            if (abort_c >= 0 && c == abort_c + 1) rst_snap = {s_dout, s_valid, s_fe, s_ov};
        end
    endtask

    initial begin
        rx_if.DataOutReady = 1'b0;
        SIn = 1'b1;
        Reset = 1'b1;
        repeat (3) step(1'b1, 1'b0, 1'b1);
        check("reset_dataout", s_dout, 8'h00);
        check("reset_valid", s_valid, 1'b0);
        check("reset_framing", s_fe, 1'b0);
        check("reset_overrun", s_ov, 1'b0);
        repeat (20) step(1'b1, 1'b1, 1'b0);

        // 0xA5 with Ready high; nominal latency 156 cycles from the start-bit drive, +/-1 accepted
        clear_mon();
        send_frame(8'hA5, 1'b1, 1'b1, -1, -1);
        repeat (5) step(1'b1, 1'b1, 1'b0);
        check("a5_latency_ok", (first_valid - t0 >= 155) && (first_valid - t0 <= 157), 1'b1);
        check("a5_data", data_at_valid, 8'hA5);
        check("a5_valid_cycles", n_valid, 1);
        check("a5_framing", n_fe, 0);
        check("a5_overrun", n_ov, 0);

        // 0x3C then 0xFF back-to-back with Ready low
        clear_mon();
        send_frame(8'h3C, 1'b1, 1'b0, -1, -1);
        send_frame(8'hFF, 1'b1, 1'b0, -1, -1);
        check("ovr_first_data", data_at_valid, 8'h3C);
        check("ovr_pulses", n_ov, 1);
        check("ovr_framing", n_fe, 0);
        check("ovr_held_data", s_dout, 8'h3C);
        check("ovr_held_valid", s_valid, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("ovr_accept_valid", s_valid, 1'b0);
        check("ovr_accept_data", s_dout, 8'h3C);

        // 0x00 with a low stop bit, then line held low
        clear_mon();
        send_frame(8'h00, 1'b0, 1'b1, -1, -1);
        repeat (40) step(1'b0, 1'b1, 1'b0);
        repeat (20) step(1'b1, 1'b1, 1'b0);
        check("fe_pulses", n_fe, 1);
        check("fe_no_valid", n_valid, 0);
        check("fe_overrun", n_ov, 0);

        // 3-cycle low glitch, then 0x81
        clear_mon();
        repeat (3) step(1'b0, 1'b1, 1'b0);
        repeat (30) step(1'b1, 1'b1, 1'b0);
        check("glitch_no_valid", n_valid, 0);
        check("glitch_no_framing", n_fe, 0);
        clear_mon();
        send_frame(8'h81, 1'b1, 1'b1, -1, -1);
        repeat (5) step(1'b1, 1'b1, 1'b0);
        check("g81_data", data_at_valid, 8'h81);
        check("g81_valid_cycles", n_valid, 1);

        // Reset during data bit 4 of 0x5A, then 0x96
        clear_mon();
        send_frame(8'h5A, 1'b1, 1'b1, -1, 88);
        repeat (40) step(1'b1, 1'b1, 1'b0);
        check("rst_outputs_zero", rst_snap, 11'h000);
        check("rst_no_valid", n_valid, 0);
        check("rst_no_framing", n_fe, 0);
        clear_mon();
        send_frame(8'h96, 1'b1, 1'b1, -1, -1);
        repeat (5) step(1'b1, 1'b1, 1'b0);
        check("r96_data", data_at_valid, 8'h96);
        check("r96_valid_cycles", n_valid, 1);

        // 0x12 held, Ready pulsed in the cycle 0x34 commits
        clear_mon();
        send_frame(8'h12, 1'b1, 1'b0, -1, -1);
        check("same_held_valid", s_valid, 1'b1);
        check("same_held_data", s_dout, 8'h12);
        clear_mon();
        send_frame(8'h34, 1'b1, 1'b0, 155, -1);
        check("same_new_data", s_dout, 8'h34);
        check("same_valid_kept", s_valid, 1'b1);
        check("same_no_overrun", n_ov, 0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("same_accept_valid", s_valid, 1'b0);

        check("dataout_stable_while_valid", dout_viol, 0);
        check("framing_overrun_exclusive", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
